// File: rtl/id_ex_skid_reg_if.sv
// ---------------------------------------------------------------------------
// id_ex_skid_reg_if
//
// Bundles the decode-side (in_*) and execute-side (out_*) signals of the
// ID/EX pipeline register.
//
// Modports:
//   master : the environment around the stage. It drives the decode fields,
//            in_valid and out_ready, and observes the EX-side fields,
//            in_ready and occupancy.
//   slave  : the pipeline register itself.
//
// Signals:
//   in_valid / in_ready    decode handshake
//   in_ops                 NUM_OPS operand words, word k at [k*DATA_W +: DATA_W]
//   in_pc, in_instr        program counter and instruction word
//   in_ctrl                packed control bits
//   in_rs1/in_rs2/in_rd    register indices
//   out_valid / out_ready  execute handshake
//   out_*                  held instruction fields (out_ctrl gated by valid)
//   occupancy              number of held entries, 0..2
// ---------------------------------------------------------------------------
interface id_ex_skid_reg_if #(
    parameter int DATA_W  = 64,
    parameter int NUM_OPS = 4,
    parameter int PC_W    = 8,
    parameter int INSTR_W = 32,
    parameter int CTRL_W  = 8,
    parameter int REG_W   = 5
);
    logic                      in_valid;
    logic                      in_ready;
    logic [NUM_OPS*DATA_W-1:0] in_ops;
    logic [PC_W-1:0]           in_pc;
    logic [INSTR_W-1:0]        in_instr;
    logic [CTRL_W-1:0]         in_ctrl;
    logic [REG_W-1:0]          in_rs1;
    logic [REG_W-1:0]          in_rs2;
    logic [REG_W-1:0]          in_rd;

    logic                      out_valid;
    logic                      out_ready;
    logic [NUM_OPS*DATA_W-1:0] out_ops;
    logic [PC_W-1:0]           out_pc;
    logic [INSTR_W-1:0]        out_instr;
    logic [CTRL_W-1:0]         out_ctrl;
    logic [REG_W-1:0]          out_rs1;
    logic [REG_W-1:0]          out_rs2;
    logic [REG_W-1:0]          out_rd;

    logic [1:0]                occupancy;

    modport master (
        output in_valid, in_ops, in_pc, in_instr, in_ctrl, in_rs1, in_rs2, in_rd,
        output out_ready,
        input  in_ready,
        input  out_valid, out_ops, out_pc, out_instr, out_ctrl, out_rs1, out_rs2, out_rd,
        input  occupancy
    );

    modport slave (
        input  in_valid, in_ops, in_pc, in_instr, in_ctrl, in_rs1, in_rs2, in_rd,
        input  out_ready,
        output in_ready,
        output out_valid, out_ops, out_pc, out_instr, out_ctrl, out_rs1, out_rs2, out_rd,
        output occupancy
    );
endinterface

// File: rtl/id_ex_skid_reg.sv
// ---------------------------------------------------------------------------
// id_ex_skid_reg
//
// ID/EX pipeline register with a valid/ready handshake and a two-entry skid
// buffer. The main entry M drives the execute side; the skid entry S catches
// the one instruction that decode can still push in the cycle execute stalls.
// in_ready is the inverse of the skid valid bit, so it comes from a flop and
// has no combinational path from out_ready. Control bits presented to EX are
// forced to zero whenever no valid instruction is held, so write-enables
// never leak into execute.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset, priority over flush
//   flush      synchronous; drops every held entry and the one being accepted
//   bus        id_ex_skid_reg_if.slave carrying both handshakes and fields
//
// Parameters must match those of the connected interface instance.
// ---------------------------------------------------------------------------
module id_ex_skid_reg #(
    parameter int DATA_W  = 64,
    parameter int NUM_OPS = 4,
    parameter int PC_W    = 8,
    parameter int INSTR_W = 32,
    parameter int CTRL_W  = 8,
    parameter int REG_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    id_ex_skid_reg_if.slave   bus
);

    // One held instruction: every field that travels from decode to execute.
    typedef struct packed {
        logic [NUM_OPS*DATA_W-1:0] ops;
        logic [PC_W-1:0]           pc;
        logic [INSTR_W-1:0]        instr;
        logic [CTRL_W-1:0]         ctrl;
        logic [REG_W-1:0]          rs1;
        logic [REG_W-1:0]          rs2;
        logic [REG_W-1:0]          rd;
    } entry_t;

    entry_t m_q;    // main entry, drives the outputs
    entry_t s_q;    // skid entry
    logic   mv_q;   // main entry valid
    logic   sv_q;   // skid entry valid

    entry_t in_entry;
    logic   accept;
    logic   issue;
    logic   m_free;

    assign in_entry = '{
        ops:   bus.in_ops,
        pc:    bus.in_pc,
        instr: bus.in_instr,
        ctrl:  bus.in_ctrl,
        rs1:   bus.in_rs1,
        rs2:   bus.in_rs2,
        rd:    bus.in_rd
    };

    // in_ready depends only on the skid flop, never on out_ready.
    assign bus.in_ready = ~sv_q;

    assign accept = bus.in_valid & ~sv_q;
    assign issue  = mv_q & bus.out_ready;

    // M can take a new value when empty or when it is leaving this cycle.
    assign m_free = ~mv_q | issue;

    always_ff @(posedge clk) begin
        // NOTE: state flops use non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (rst) begin
            // NOTE: the data entries are cleared too so every output reads
            // zero out of reset; these are two entries, not a memory array.
            mv_q <= 1'b0;
            sv_q <= 1'b0;
            m_q  <= '0;
            s_q  <= '0;
        end else if (flush) begin
            // Data fields may keep stale contents; only validity is dropped.
            mv_q <= 1'b0;
            sv_q <= 1'b0;
        end else if (m_free) begin
            if (sv_q) begin
                // Drain skid first to keep strict FIFO order; accept is
                // impossible here because in_ready is low.
                m_q  <= s_q;
                mv_q <= 1'b1;
                sv_q <= 1'b0;
            end else if (accept) begin
                m_q  <= in_entry;
                mv_q <= 1'b1;
            end else begin
                mv_q <= 1'b0;
            end
        end else if (accept) begin
            // M is stalled: the instruction accepted this cycle parks in S.
            s_q  <= in_entry;
            sv_q <= 1'b1;
        end
    end

    assign bus.out_valid = mv_q;
    assign bus.out_ops   = m_q.ops;
    assign bus.out_pc    = m_q.pc;
    assign bus.out_instr = m_q.instr;
    assign bus.out_rs1   = m_q.rs1;
    assign bus.out_rs2   = m_q.rs2;
    assign bus.out_rd    = m_q.rd;

    // Combinational gating so ctrl is zero in the very cycle valid is low.
    assign bus.out_ctrl  = mv_q ? m_q.ctrl : '0;

    assign bus.occupancy = {1'b0, mv_q} + {1'b0, sv_q};

endmodule
